// File: rtl/maindec_pipe.sv
// RV32 main decoder behind a valid/ready handshake: one output register plus a skid entry,
// so in_ready comes straight from a flop. Counts illegal bundles handed to execute.
module maindec_pipe #(
  parameter int HAS_M = 0,
  parameter int ALUW  = 5,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [ALUW-1:0] alucontrol,
  output logic            regwrite,
  output logic            memwrite,
  output logic            memread,
  output logic            branch,
  output logic            jump,
  output logic            alusrc,
  output logic [1:0]      resultsrc,
  output logic [2:0]      immsrc,
  output logic            illegal,
  output logic [CNTW-1:0] illegal_count
);

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  localparam logic [4:0] ALU_MUL   = 5'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  alu;
    logic        regwrite;
    logic        memwrite;
    logic        memread;
    logic        branch;
    logic        jump;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  immsrc;
    logic        illegal;
  } bundle_t;

  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  bundle_t              dec;
  bundle_t              out_reg;
  bundle_t              skid_reg;
  logic                 out_valid_reg;
  logic                 skid_valid_reg;
  logic                 in_ready_reg;
  logic [CNTW-1:0]      count_reg;
  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic                 bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec       = '0;
    dec.instr = instr;
    bad       = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec.regwrite  = 1'b1;
        dec.memread   = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 2'd1;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.immsrc   = 3'd1;
        bad = (f3 >= 3'b011);
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.immsrc = 3'd2;
        dec.alu    = ALU_SUB;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_OP: begin
        dec.regwrite = 1'b1;
        if (f7 == F7_BASE) begin
          dec.alu = base_alu(f3);
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000)      dec.alu = ALU_SUB;
          else if (f3 == 3'b101) dec.alu = ALU_SRA;
          else                   bad = 1'b1;
        end else if (HAS_M != 0 && f7 == F7_MULD) begin
          dec.alu = ALU_MUL + {2'b00, f3};
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu      = base_alu(f3);
        // Only the shift forms carry a funct7 field; the others use it as immediate bits.
        if (f3 == 3'b001) begin
          bad = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          if (f7 == F7_ALT)       dec.alu = ALU_SRA;
          else if (f7 != F7_BASE) bad = 1'b1;
        end
      end
      OP_JAL: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultsrc = 2'd2;
        dec.immsrc    = 3'd4;
      end
      OP_JALR: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.alusrc    = 1'b1;
        dec.resultsrc = 2'd2;
        bad = (f3 != 3'b000);
      end
      OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.immsrc   = 3'd3;
        dec.alu      = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.immsrc   = 3'd3;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.instr   = instr;
      dec.illegal = 1'b1;
    end
  end

  logic accept;
  logic take;
  assign accept = in_valid && in_ready_reg;
  assign take   = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
      count_reg      <= '0;
    end else begin
      // A hand-off counts even in a flush cycle: execute has already taken it.
      if (take && out_reg.illegal && count_reg != '1)
        count_reg <= count_reg + CNTW'(1);
      if (flush) begin
        out_valid_reg  <= 1'b0;
        skid_valid_reg <= 1'b0;
        in_ready_reg   <= 1'b1;
      end else if (!out_valid_reg || out_ready) begin
        if (skid_valid_reg) begin
          out_reg        <= skid_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= 1'b0;
          in_ready_reg   <= 1'b1;
        end else if (accept) begin
          out_reg       <= dec;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        skid_reg       <= dec;
        skid_valid_reg <= 1'b1;
        in_ready_reg   <= 1'b0;
      end
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_instr     = out_reg.instr;
  assign alucontrol    = ALUW'(out_reg.alu);
  assign regwrite      = out_reg.regwrite;
  assign memwrite      = out_reg.memwrite;
  assign memread       = out_reg.memread;
  assign branch        = out_reg.branch;
  assign jump          = out_reg.jump;
  assign alusrc        = out_reg.alusrc;
  assign resultsrc     = out_reg.resultsrc;
  assign immsrc        = out_reg.immsrc;
  assign illegal       = out_reg.illegal;
  assign illegal_count = count_reg;

endmodule
